add_seq_master: RTL and testbench
=================================

// Module: add_seq_master
// PURPOSE
//  Initiator side of the fixed-point adder handshake (cs_add/rdy_add, x/y/sum). Accumulates a
//  stream of N 16-bit sign-magnitude Q8.7 operands by issuing repeated two-operand adds to the
//  adder and returning the final sum. Sits between the GRU gate datapath (operand stream) and
//  the shared adder unit, e.g. summing gate pre-activation partial products.
// PARAMETERS
//  W        16  operand/result width, sign-magnitude (bit W-1 = sign, W-2:0 = magnitude)
//  LEN_W    8   width of element-count input (N = 0..2**LEN_W-1)
//  TIMEOUT  16  max cycles to wait for each adder handshake phase before flagging err
// PORTS
//  clk      in   1      clock; all state changes on rising edge
//  rst      in   1      asynchronous, active-low reset
//  start    in   1      1-cycle request to begin accumulation; sampled only in IDLE
//  len      in   LEN_W  element count N, sampled with start
//  in_valid in   1      operand valid
//  in_data  in   W      operand, sign-magnitude Q8.7
//  in_ready out  1      operand accepted when in_valid & in_ready
//  busy     out  1      high from accepted start until done/err
//  done     out  1      1-cycle pulse: result valid
//  err      out  1      1-cycle pulse: adder handshake timeout; operation aborted
//  result   out  W      final sum, held until next accepted start
//  cs_add   out  1      adder request, exactly 1 cycle per add
//  x        out  W      adder operand A (running accumulator), held stable start->capture
//  y        out  W      adder operand B (current element), held stable start->capture
//  sum      in   W      adder result, valid when rdy_add returns high
//  rdy_add  in   1      adder idle/ready
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; in_ready, busy, done, err, cs_add = 0; result, x, y, acc = 0.
//  FSM states: IDLE, LOAD, FETCH, ISSUE, WAIT_BUSY, WAIT_RDY, FIN.
//  IDLE: start=1 -> latch len into cnt; len==0 -> FIN with acc=0; else -> LOAD. busy=1 from next cycle.
//  LOAD: in_ready=1; on handshake acc<=in_data, cnt-=1; cnt (after decrement)==0 -> FIN else FETCH.
//  FETCH: in_ready=1; on handshake y<=in_data, x<=acc -> ISSUE.
//  ISSUE: if rdy_add=1, assert cs_add for this one cycle -> WAIT_BUSY; else wait (timeout counted).
//  WAIT_BUSY: wait for rdy_add=0 (adder accepted) -> WAIT_RDY.
//  WAIT_RDY: on rdy_add=1: acc<=sum (16'h8000 canonicalised to 16'h0000), cnt-=1;
//    cnt (after decrement)==0 -> FIN else FETCH.
//  FIN: result<=acc, done=1 for 1 cycle, busy=0 -> IDLE.
//  Timeout: cycle counter cleared on each entry to ISSUE/WAIT_BUSY/WAIT_RDY; counter reaching
//    TIMEOUT -> err pulse 1 cycle, cs_add=0, busy=0, result unchanged -> IDLE.
//  Per-add latency with nominal adder: ISSUE 1 + adder busy 2 + capture 1 = 4 cycles min.
//  in_ready=0 in all states except LOAD/FETCH; operands never dropped or duplicated.
//  start while busy: ignored. start and in_valid same cycle in IDLE: operand not accepted.
//  No saturation; overflow wraps as the adder produces it (caller scales Q8.7 inputs).
//  rst low mid-operation: immediate abort, outputs to reset values, no done/err pulse.
//  x, y registered; never change between cs_add and the sum capture.
// STRUCTURE
//  Shared package add_pkg: W_FX=16, Q_FRAC=7, NEG_ZERO=16'h8000, FSM state enum add_seq_state_t.
//  Single module; timeout counter inline. No sub-module. Bench instantiates addss as responder.
// TESTING
//  1 len=3, ops 0x0080,0x0100,0x8040 (1.0,2.0,-0.5) -> two cs_add pulses, done, result=0x0140.
//  2 len=1, op 0x8123 -> no cs_add, done 2 cycles after operand, result=0x8123.
//  3 len=0 -> no in_ready, done one cycle after FIN entry, result=0x0000.
//  4 len=4, in_valid toggled 1-of-3 cycles; ops 0x0010 x4 -> result=0x0040; x/y stable checked.
//  5 adder stub holds rdy_add=1 forever after cs_add -> err pulse after TIMEOUT(16) cycles, busy=0.
//  6 rst=0 during WAIT_RDY, then re-start len=2 ops 0x0080,0x8080 -> result=0x0000, no stale done.

Source files
------------

// File: rtl/add_pkg.sv
// Shared definitions for the fixed-point adder handshake: Q8.7 sign-magnitude format
// constants and the accumulation sequencer state encoding.
package add_pkg;
    localparam int W_FX   = 16;
    localparam int Q_FRAC = 7;
    localparam logic [W_FX-1:0] NEG_ZERO = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_RDY,
        S_FIN
    } add_seq_state_t;
endpackage

// File: rtl/add_seq_master.sv
// Accumulates N sign-magnitude operands by issuing repeated two-operand adds to a shared
// adder over the cs_add/rdy_add handshake; aborts with err if the adder stops responding.
module add_seq_master
    import add_pkg::*;
#(
    parameter int W       = W_FX,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     result,
    output logic             cs_add,
    output logic [W-1:0]     x,
    output logic [W-1:0]     y,
    input  logic [W-1:0]     sum,
    input  logic             rdy_add
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] NEG_Z = {1'b1, {(W-1){1'b0}}};

    add_seq_state_t   state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     y_q, y_d;
    logic [W-1:0]     result_q, result_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tmo_hit;
    logic             last_elem;

    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
    assign last_elem = (cnt_q == LEN_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        tmo_d    = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d  = len;
                    busy_d = 1'b1;
                    if (len == '0) begin
                        acc_d   = '0;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = last_elem ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    x_d     = acc_q;
                    y_d     = in_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT_BUSY, S_WAIT_RDY: begin
                tmo_d = tmo_q + TW'(1);
                // Timeout outranks a same-cycle handshake so an abort never issues a request.
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (state_q == S_ISSUE && rdy_add) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_BUSY;
                end else if (state_q == S_WAIT_BUSY && !rdy_add) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_RDY;
                end else if (state_q == S_WAIT_RDY && rdy_add) begin
                    // The adder may return negative zero; keep the accumulator canonical.
                    acc_d   = (sum == NEG_Z) ? '0 : sum;
                    cnt_d   = cnt_q - LEN_W'(1);
                    tmo_d   = '0;
                    state_d = last_elem ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_LOAD) || (state_q == S_FETCH);
        cs_add   = (state_q == S_ISSUE) && rdy_add && !tmo_hit;
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign x      = x_q;
    assign y      = y_q;
endmodule

// File: tb/tb_add_seq_master.sv
// Scoreboard bench for add_seq_master with a behavioural sign-magnitude adder responder.
module tb_add_seq_master;
    localparam int TIMEOUT = 16;

    logic        clk, rst, start, in_valid, in_ready, busy, done, err, cs_add, rdy_add;
    logic [7:0]  len;
    logic [15:0] in_data, result, x, y, sum;

    add_seq_master #(.W(16), .LEN_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .busy(busy), .done(done), .err(err),
        .result(result), .cs_add(cs_add), .x(x), .y(y), .sum(sum), .rdy_add(rdy_add)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rdy_cnt = 0;

    typedef struct {
        logic [15:0] res;
        bit          is_err;
        int          adds;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sign-magnitude adder; equal magnitudes of opposite sign yield negative zero when b is negative.
    function automatic logic [15:0] sm_add(input logic [15:0] a, input logic [15:0] b);
        logic [14:0] ma, mb, m;
        logic s;
        ma = a[14:0];
        mb = b[14:0];
        if (a[15] == b[15]) begin
            m = ma + mb;
            s = a[15];
        end else if (ma > mb) begin
            m = ma - mb;
            s = a[15];
        end else begin
            m = mb - ma;
            s = b[15];
        end
        return {s, m};
    endfunction

    // Adder responder: idle high, busy 2 cycles after cs_add; 'stuck' ignores requests.
    logic stuck = 1'b0;
    int   abusy;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_add <= 1'b1;
            abusy   <= 0;
            sum     <= '0;
        end else if (abusy > 0) begin
            abusy <= abusy - 1;
            if (abusy == 1) rdy_add <= 1'b1;
        end else if (cs_add && !stuck) begin
            rdy_add <= 1'b0;
            abusy   <= 2;
            sum     <= sm_add(x, y);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected results on done/err, counts adds, checks x/y stability.
    int          adds = 0;
    int          last_cs = 0;
    bit          watching = 0;
    bit          stable = 1;
    logic [15:0] xs, ys;
    always @(negedge clk) begin
        if (!rst) begin
            adds     = 0;
            watching = 0;
        end else begin
            if (in_ready) rdy_cnt++;
            if (cs_add) begin
                adds++;
                last_cs  = cyc;
                xs       = x;
                ys       = y;
                watching = 1;
                stable   = 1;
            end else if (watching) begin
                if (x !== xs || y !== ys) stable = 0;
                if (in_ready || done || err) begin
                    check("xy_stable", int'(stable), 1);
                    watching = 0;
                end
            end
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_end: done=%0b err=%0b result=%h", done, err, result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", int'(result), int'(e.res));
                    check("err_flag", int'(err), int'(e.is_err));
                    check("add_count", adds, e.adds);
                    check("busy_at_end", int'(busy), 0);
                    if (err) check("err_latency", cyc - last_cs, TIMEOUT + 1);
                end
                adds = 0;
            end
        end
    end

    task automatic do_start(input logic [7:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        len   = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake edge.
    task automatic feed(input logic [15:0] op, input int gap);
        bit ok;
        int guard;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = op;
        ok       = 0;
        guard    = 0;
        while (!ok && guard < 200) begin
            ok = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!ok) check("feed_timeout", 0, 1);
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (done || err) break;
        end
        if (!(done || err)) check("end_timeout", 0, 1);
    endtask

    int n;
    initial begin
        rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_cs_add", int'(cs_add), 0);
        check("rst_result", int'(result), 0);
        check("rst_xy", int'({x, y}), 0);
        rst = 1'b1;

        // 1: 1.0 + 2.0 - 0.5 = 2.5
        exp_q.push_back('{16'h0140, 1'b0, 2});
        do_start(8'd3);
        check("t1_busy", int'(busy), 1);
        feed(16'h0080, 0);
        feed(16'h0100, 0);
        feed(16'h8040, 0);
        wait_end(n);

        // 2: single operand passes through
        exp_q.push_back('{16'h8123, 1'b0, 0});
        do_start(8'd1);
        feed(16'h8123, 0);
        wait_end(n);
        check("t2_latency", n, 2);

        // 3: empty stream; offered operand must not be taken
        exp_q.push_back('{16'h0000, 1'b0, 0});
        rdy_cnt  = 0;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        do_start(8'd0);
        wait_end(n);
        in_valid = 1'b0;
        check("t3_latency", n, 2);
        check("t3_no_ready", rdy_cnt, 0);

        // 4: sparse operands, plus a start pulse while busy that must be ignored
        exp_q.push_back('{16'h0040, 1'b0, 3});
        do_start(8'd4);
        feed(16'h0010, 2);
        start = 1'b1;
        len   = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        feed(16'h0010, 2);
        feed(16'h0010, 2);
        feed(16'h0010, 2);
        wait_end(n);

        // 5: adder never goes busy -> timeout, result keeps previous value
        stuck = 1'b1;
        exp_q.push_back('{16'h0040, 1'b1, 1});
        do_start(8'd2);
        feed(16'h0001, 0);
        feed(16'h0002, 0);
        wait_end(n);
        stuck = 1'b0;
        repeat (3) @(posedge clk); #1;

        // 6: reset while waiting on the adder, then a clean run ending in negative zero
        do_start(8'd2);
        feed(16'h0080, 0);
        feed(16'h0040, 0);
        n = 0;
        while (!cs_add && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_saw_cs_add", int'(cs_add), 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_result", int'(result), 0);
        check("t6_rst_cs_add", int'(cs_add), 0);
        check("t6_rst_xy", int'({x, y}), 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back('{16'h0000, 1'b0, 1});
        do_start(8'd2);
        feed(16'h0080, 0);
        feed(16'h8080, 0);
        wait_end(n);

        repeat (5) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
